csr_trap_unit: RTL



---
 rtl/csr_trap_unit_if.sv | 40 ++++
 rtl/csr_trap_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_unit_if
// Description : MA-stage to CSR/trap unit bus. The pipeline drives the
//               instruction side and receives CSR read data and the fetch
//               redirect.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_trap_unit_if #(
    parameter int XLEN = 32
);
    logic            ma_valid;
    logic            csr_en;
    logic [2:0]      csr_funct3;
    logic [11:0]     csr_addr;
    logic [4:0]      csr_rs1;
    logic [XLEN-1:0] csr_wdata;
    logic            is_mret;
    logic            instr_retire;
    logic [XLEN-1:0] pc_ma;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    // Pipeline side
    modport master (
        output ma_valid, csr_en, csr_funct3, csr_addr, csr_rs1, csr_wdata,
               is_mret, instr_retire, pc_ma,
        input  csr_rdata, csr_illegal, redirect_valid, redirect_pc
    );

    // CSR/trap unit side
    modport slave (
        input  ma_valid, csr_en, csr_funct3, csr_addr, csr_rs1, csr_wdata,
               is_mret, instr_retire, pc_ma,
        output csr_rdata, csr_illegal, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_unit
// Description : Machine-mode CSR file (Zicsr), 64-bit cycle/instret counters
//               and level-sensitive interrupt controller with a RUN/FLUSH
//               commit FSM that issues a registered PC redirect to fetch.
//               Only XLEN = 32 is supported.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_trap_unit #(
    parameter int          XLEN        = 32,
    parameter int          NUM_IRQ     = 2,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    csr_trap_unit_if.slave     bus
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // mip bit / cause number of interrupt line k
    function automatic logic [4:0] irq_bit(input int k);
        if (k == 0)      return 5'd7;
        else if (k == 1) return 5'd11;
        else             return 5'(14 + k);
    endfunction

    state_t      state, state_d;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] mip;
    logic [31:0] mip_mask;
    logic [31:0] pend;
    logic [4:0]  irq_cause;
    logic        take_irq;
    logic        mret_commit;
    logic [31:0] trap_target;

    logic [31:0] old_val;
    logic        addr_legal;
    logic [31:0] operand;
    logic [31:0] wr_val;
    logic        wr_req;
    logic        wr_en;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Map interrupt lines onto mip bit positions; mask marks writable mie bits
    always_comb begin
        mip      = '0;
        mip_mask = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            mip[irq_bit(k)]      = irq_in[k];
            mip_mask[irq_bit(k)] = 1'b1;
        end
    end

    assign pend = mip & mie;

    // Priority: external, then timer, then lowest-numbered local line
    always_comb begin
        irq_cause = 5'd0;
        for (int k = NUM_IRQ - 1; k >= 2; k--) begin
            if (pend[irq_bit(k)]) irq_cause = irq_bit(k);
        end
        if (pend[7])  irq_cause = 5'd7;
        if (pend[11]) irq_cause = 5'd11;
    end

    assign take_irq    = mstatus_mie && (|pend) && bus.ma_valid && (state == ST_RUN);
    assign mret_commit = bus.ma_valid && bus.is_mret && (state == ST_RUN) && !take_irq;
    assign trap_target = {mtvec[31:2], 2'b00}
                       + (mtvec[0] ? {25'b0, irq_cause, 2'b00} : 32'd0);

    // CSR read mux; also flags unimplemented addresses
    always_comb begin
        old_val    = '0;
        addr_legal = 1'b1;
        case (bus.csr_addr)
            ADDR_MSTATUS:   old_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            ADDR_MIE:       old_val = mie;
            ADDR_MTVEC:     old_val = mtvec;
            ADDR_MSCRATCH:  old_val = mscratch;
            ADDR_MEPC:      old_val = mepc;
            ADDR_MCAUSE:    old_val = mcause;
            ADDR_MIP:       old_val = mip;
            ADDR_MCYCLE:    old_val = mcycle[31:0];
            ADDR_MCYCLEH:   old_val = mcycle[63:32];
            ADDR_MINSTRET:  old_val = minstret[31:0];
            ADDR_MINSTRETH: old_val = minstret[63:32];
            default:        addr_legal = 1'b0;
        endcase
    end

    // Zicsr write value; set/clear forms with rs1/uimm == 0 are read-only
    always_comb begin
        operand = bus.csr_funct3[2] ? {27'b0, bus.csr_rs1} : bus.csr_wdata;
        wr_val  = operand;
        wr_req  = 1'b0;
        case (bus.csr_funct3[1:0])
            2'b01: begin
                wr_val = operand;
                wr_req = 1'b1;
            end
            2'b10: begin
                wr_val = old_val | operand;
                wr_req = (bus.csr_rs1 != 5'd0);
            end
            2'b11: begin
                wr_val = old_val & ~operand;
                wr_req = (bus.csr_rs1 != 5'd0);
            end
            default: begin
                wr_val = operand;
                wr_req = 1'b0;
            end
        endcase
    end

    assign wr_en = bus.ma_valid && bus.csr_en && (state == ST_RUN) && !take_irq
                 && addr_legal && wr_req;

    // Trap CSRs: trap entry beats MRET, which beats an explicit CSR write
    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie          <= '0;
            mtvec        <= RESET_MTVEC;
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
        end else if (take_irq) begin
            mepc         <= bus.pc_ma & ~32'h3;
            mcause       <= {1'b1, 26'b0, irq_cause};
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_commit) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (wr_en) begin
            case (bus.csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie  <= wr_val[3];
                    mstatus_mpie <= wr_val[7];
                end
                ADDR_MIE:      mie      <= wr_val & mip_mask;
                ADDR_MTVEC:    mtvec    <= {wr_val[31:2], wr_val[1] ? 2'b00 : wr_val[1:0]};
                ADDR_MSCRATCH: mscratch <= wr_val;
                ADDR_MEPC:     mepc     <= wr_val & ~32'h3;
                ADDR_MCAUSE:   mcause   <= wr_val;
                default:       ;
            endcase
        end
    end

    // 64-bit counters; a write to one half replaces that half and freezes the other
    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_en && bus.csr_addr == ADDR_MCYCLE)
                mcycle <= {mcycle[63:32], wr_val};
            else if (wr_en && bus.csr_addr == ADDR_MCYCLEH)
                mcycle <= {wr_val, mcycle[31:0]};
            else
                mcycle <= mcycle + 64'd1;

            if (wr_en && bus.csr_addr == ADDR_MINSTRET)
                minstret <= {minstret[63:32], wr_val};
            else if (wr_en && bus.csr_addr == ADDR_MINSTRETH)
                minstret <= {wr_val, minstret[31:0]};
            else if (bus.instr_retire)
                minstret <= minstret + 64'd1;
        end
    end

    // State register and registered redirect to fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_RUN;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_d;
            redirect_valid <= take_irq || mret_commit;
            if (take_irq)
                redirect_pc <= trap_target;
            else if (mret_commit)
                redirect_pc <= mepc;
        end
    end

    // Next state: commit enters FLUSH for exactly one cycle
    always_comb begin
        state_d = state;
        case (state)
            ST_RUN:   if (take_irq || mret_commit) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    assign bus.csr_rdata      = old_val;
    assign bus.csr_illegal    = bus.csr_en && bus.ma_valid && !addr_legal;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;

endmodule
`default_nettype wire
